// File: rtl/fifo_stream_reader_if.sv
// Bundles the FIFO read port and the valid/ready output stream of the reader.
// master = the reader (drives fifo_rd and the stream), slave = FIFO plus sink.
interface fifo_stream_reader_if #(
  parameter int DATA_W = 8
);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_rd;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;

  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_rd, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_rd, m_valid, m_data
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Consumer-side controller for an 8-bit synchronous FIFO. Bytes are popped
// with fifo_rd, captured one cycle later into a small circular skid buffer and
// re-presented on a valid/ready stream. A read is only issued when the buffer
// has room for every byte already requested (occ + inflight), so a byte can
// never arrive at a full buffer and the FIFO is never read while empty.
module fifo_stream_reader #(
  parameter int DATA_W    = 8,
  parameter int BUF_DEPTH = 3,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 drain_en,
  fifo_stream_reader_if.master bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     byte_cnt
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(BUF_DEPTH - 1);
  localparam logic [OCC_W:0]   CREDIT_MAX = (OCC_W + 1)'(BUF_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] buf_mem [BUF_DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [OCC_W-1:0]  occ;
  logic              inflight;
  logic              rd;
  logic              pop;
  logic              capture;
  logic [OCC_W:0]    credit_used;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign credit_used = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
  assign capture     = inflight;
  assign pop         = bus.m_valid & bus.m_ready;

  assign bus.fifo_rd = rd;
  assign bus.m_valid = (occ != '0);
  assign bus.m_data  = buf_mem[head];

  // Next-state logic plus the read strobe and busy flag derived from the state.
  always_comb begin
    state_nxt = state;
    rd        = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (drain_en) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        rd = !bus.fifo_empty && (credit_used < CREDIT_MAX);
        if (!drain_en) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (drain_en) begin
          state_nxt = ACTIVE;
        end else if (!inflight && (occ == '0)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Skid buffer: capture the byte requested last cycle, pop on handshake, count deliveries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      occ      <= '0;
      byte_cnt <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_mem[i] <= '0;
      end
    end else begin
      inflight <= rd;
      if (capture) begin
        buf_mem[tail] <= bus.fifo_data;
        tail          <= next_ptr(tail);
      end
      if (pop) begin
        head     <= next_ptr(head);
        byte_cnt <= byte_cnt + CNT_W'(1);
      end
      case ({capture, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: a behavioural sync FIFO feeds the
// reader, a scoreboard queue holds the bytes the stream must emit, and a
// cycle table plus hand-written sequences cover the multi-cycle corner cases.
module tb_fifo_stream_reader;

  logic        clk;
  logic        rst_n;
  logic        drain_en;
  logic        busy;
  logic [15:0] byte_cnt;

  fifo_stream_reader_if #(.DATA_W(8)) bus ();

  fifo_stream_reader #(
    .DATA_W    (8),
    .BUF_DEPTH (3),
    .CNT_W     (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .drain_en (drain_en),
    .bus      (bus),
    .busy     (busy),
    .byte_cnt (byte_cnt)
  );

  typedef struct {
    logic        drain;
    logic        ready;
    logic        rd;
    logic        valid;
    logic [7:0]  data;
    logic        busy;
    logic [15:0] cnt;
  } vec_t;

  vec_t       tbl [9];
  logic [7:0] fifo_q [$];
  logic [7:0] exp_q  [$];
  int         vectors;
  int         miscompares;
  int         rd_pulses;
  int         outstanding;
  logic       hold;
  logic [7:0] held_data;

  initial clk = 1'b0;
  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Behavioural sync FIFO: registered data_out and empty flag, plus credit bookkeeping.
  always @(posedge clk) begin
    if (bus.fifo_rd) begin
      rd_pulses++;
      if (fifo_q.size() > 0) bus.fifo_data <= fifo_q.pop_front();
    end
    bus.fifo_empty <= (fifo_q.size() == 0);
    if (!rst_n) outstanding = 0;
    else outstanding = outstanding + int'(bus.fifo_rd) - int'(bus.m_valid && bus.m_ready);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic drain, input logic ready);
    drain_en   = drain;
    bus.m_ready = ready;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic loadByte(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic waitIdle(input string name, input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (!busy) break;
    end
    checkOutput(name, 32'(busy), 32'd0);
  endtask

  task automatic waitDrained(input string name, input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.m_valid) break;
    end
    checkOutput(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Stream monitor: scoreboard pop on handshake, stall stability, underflow and credit checks.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        checkOutput("stall valid held", 32'(bus.m_valid), 32'd1);
        checkOutput("stall data held", 32'(bus.m_data), 32'(held_data));
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL stream byte: got 0x%0h, expected none", bus.m_data);
        end else begin
          checkOutput("stream byte", 32'(bus.m_data), 32'(exp_q.pop_front()));
        end
      end
      hold      = bus.m_valid && !bus.m_ready;
      held_data = bus.m_data;
      if (bus.fifo_rd) checkOutput("rd while empty", 32'(bus.fifo_empty), 32'd0);
      if (outstanding > 3) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL credit: got %0d outstanding, expected at most 3", outstanding);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    int base;
    int fall_base;
    int hs;
    vectors     = 0;
    miscompares = 0;
    rd_pulses   = 0;
    outstanding = 0;
    hold        = 1'b0;
    held_data   = '0;
    rst_n       = 1'b0;
    applyStimulus(1'b0, 1'b0);

    //          drain ready rd  valid data   busy cnt
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 16'd0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 16'd0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 16'd0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 16'd1};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 16'd2};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'd3};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'd3};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd3};

    repeat (3) nextCycle();
    checkOutput("reset m_valid", 32'(bus.m_valid), 32'd0);
    checkOutput("reset m_data", 32'(bus.m_data), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset byte_cnt", 32'(byte_cnt), 32'd0);
    checkOutput("reset fifo_rd", 32'(bus.fifo_rd), 32'd0);
    rst_n = 1'b1;

    // Three bytes, sink always ready, cycle-exact latency table.
    loadByte(8'h11);
    loadByte(8'h22);
    loadByte(8'h33);
    for (int i = 0; i < 9; i++) begin
      nextCycle();
      applyStimulus(tbl[i].drain, tbl[i].ready);
      @(negedge clk);
      checkOutput($sformatf("t1 c%0d fifo_rd", i), 32'(bus.fifo_rd), 32'(tbl[i].rd));
      checkOutput($sformatf("t1 c%0d m_valid", i), 32'(bus.m_valid), 32'(tbl[i].valid));
      if (tbl[i].valid) checkOutput($sformatf("t1 c%0d m_data", i), 32'(bus.m_data), 32'(tbl[i].data));
      checkOutput($sformatf("t1 c%0d busy", i), 32'(busy), 32'(tbl[i].busy));
      checkOutput($sformatf("t1 c%0d byte_cnt", i), 32'(byte_cnt), 32'(tbl[i].cnt));
    end

    // Ten bytes against a stalled sink, then release for a full-rate burst.
    for (int i = 0; i < 10; i++) loadByte(8'hA0 + 8'(i));
    nextCycle();
    base = rd_pulses;
    applyStimulus(1'b1, 1'b0);
    repeat (10) nextCycle();
    checkOutput("t2 reads while stalled", 32'(rd_pulses - base), 32'd3);
    @(negedge clk);
    checkOutput("t2 stalled m_valid", 32'(bus.m_valid), 32'd1);
    checkOutput("t2 stalled m_data", 32'(bus.m_data), 32'hA0);
    nextCycle();
    applyStimulus(1'b1, 1'b1);
    hs = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.m_valid && bus.m_ready) hs++;
    end
    checkOutput("t2 burst handshakes", 32'(hs), 32'd10);
    nextCycle();
    applyStimulus(1'b0, 1'b1);
    waitIdle("t2 idle", 50);
    checkOutput("t2 byte_cnt", 32'(byte_cnt), 32'd13);

    // Eight bytes with the sink toggling ready every cycle.
    for (int i = 0; i < 8; i++) loadByte(8'h30 + 8'(i));
    for (int c = 0; c < 100; c++) begin
      nextCycle();
      applyStimulus(1'b1, (c % 2) == 0);
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    checkOutput("t3 all delivered", 32'(exp_q.size()), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b1);
    waitIdle("t3 idle", 50);
    checkOutput("t3 byte_cnt", 32'(byte_cnt), 32'd21);

    // Drop drain_en with two bytes buffered and one in flight.
    for (int i = 0; i < 6; i++) loadByte(8'h40 + 8'(i));
    nextCycle();
    base = rd_pulses;
    applyStimulus(1'b1, 1'b0);
    for (int n = 0; n < 20; n++) begin
      nextCycle();
      if (rd_pulses - base >= 3) break;
    end
    checkOutput("t4 reads before fall", 32'(rd_pulses - base), 32'd3);
    applyStimulus(1'b0, 1'b0);
    fall_base = rd_pulses;
    nextCycle();
    applyStimulus(1'b0, 1'b1);
    waitIdle("t4 idle", 50);
    checkOutput("t4 reads after fall", 32'(rd_pulses - fall_base), 32'd0);
    checkOutput("t4 fifo retained", 32'(fifo_q.size()), 32'd3);
    checkOutput("t4 byte_cnt", 32'(byte_cnt), 32'd24);
    fifo_q.delete();
    exp_q.delete();
    nextCycle();

    // Reset pulse mid-stream with occ=2, then resume from the FIFO head.
    for (int i = 0; i < 8; i++) loadByte(8'h50 + 8'(i));
    nextCycle();
    base = rd_pulses;
    applyStimulus(1'b1, 1'b0);
    for (int n = 0; n < 20; n++) begin
      nextCycle();
      if (rd_pulses - base >= 3) break;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("t5 reset m_valid", 32'(bus.m_valid), 32'd0);
    checkOutput("t5 reset byte_cnt", 32'(byte_cnt), 32'd0);
    checkOutput("t5 reset busy", 32'(busy), 32'd0);
    checkOutput("t5 reset fifo_rd", 32'(bus.fifo_rd), 32'd0);
    checkOutput("t5 fifo left", 32'(fifo_q.size()), 32'd5);
    exp_q = fifo_q;
    nextCycle();
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1);
    waitDrained("t5 resumed drain", 100);
    checkOutput("t5 byte_cnt", 32'(byte_cnt), 32'd5);
    nextCycle();
    applyStimulus(1'b0, 1'b1);
    waitIdle("t5 idle", 50);

    // 65537 bytes: byte_cnt wraps to 1.
    rst_n = 1'b0;
    nextCycle();
    rst_n = 1'b1;
    for (int i = 0; i < 65537; i++) loadByte(8'($urandom_range(0, 255)));
    nextCycle();
    applyStimulus(1'b1, 1'b1);
    waitDrained("t6 drained", 70000);
    checkOutput("t6 byte_cnt wrap", 32'(byte_cnt), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b1);
    waitIdle("t6 idle", 50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
